// File: rtl/bip_control_unit.sv
// bip_control_unit: fetch/decode controller for the BIP data path.
// Holds the program counter, the IDLE/RUN/HALT sequencer and the
// executed-instruction counter. Decoded selects are combinational from the
// fetched word and are forced to zero whenever the unit is not running.
module bip_control_unit #(
  parameter int NBITS_I   = 16,
  parameter int NBITS_OPC = 5,
  parameter int NBITS_O   = 11,
  parameter int NBITS_PC  = 11,
  parameter int NBITS_CNT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NBITS_I-1:0]   i_Instruction,
  output logic [NBITS_PC-1:0]  o_PC,
  output logic [1:0]           o_SelA,
  output logic                 o_SelB,
  output logic                 o_WrAcc,
  output logic                 o_Op,
  output logic [NBITS_O-1:0]   o_Operand,
  output logic                 o_RdRam,
  output logic                 o_WrRam,
  output logic                 o_Halt,
  output logic [NBITS_CNT-1:0] o_CycleCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [NBITS_OPC-1:0] OPC_HLT  = NBITS_OPC'(0);
  localparam logic [NBITS_OPC-1:0] OPC_STO  = NBITS_OPC'(1);
  localparam logic [NBITS_OPC-1:0] OPC_LD   = NBITS_OPC'(2);
  localparam logic [NBITS_OPC-1:0] OPC_LDI  = NBITS_OPC'(3);
  localparam logic [NBITS_OPC-1:0] OPC_ADD  = NBITS_OPC'(4);
  localparam logic [NBITS_OPC-1:0] OPC_ADDI = NBITS_OPC'(5);
  localparam logic [NBITS_OPC-1:0] OPC_SUB  = NBITS_OPC'(6);
  localparam logic [NBITS_OPC-1:0] OPC_SUBI = NBITS_OPC'(7);

  state_t               state_q, state_d;
  logic [NBITS_PC-1:0]  pc_q, pc_d;
  logic [NBITS_CNT-1:0] cnt_q, cnt_d;
  logic [NBITS_OPC-1:0] opcode;
  logic                 running;

  assign opcode  = i_Instruction[NBITS_I-1 -: NBITS_OPC];
  assign running = (state_q == RUN);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [NBITS_CNT-1:0] sat_inc(input logic [NBITS_CNT-1:0] v);
    return (&v) ? v : v + NBITS_CNT'(1);
  endfunction

  // State, program counter and instruction counter registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer: start (re)launches from PC 0, HLT parks the PC and stops.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (i_start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = sat_inc(cnt_q);
        if (opcode == OPC_HLT) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + NBITS_PC'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Instruction decode, gated so nothing reaches the data path unless running.
  always_comb begin
    o_SelA    = 2'b00;
    o_SelB    = 1'b0;
    o_Op      = 1'b0;
    o_WrAcc   = 1'b0;
    o_RdRam   = 1'b0;
    o_WrRam   = 1'b0;
    o_Operand = '0;
    if (running) begin
      o_Operand = i_Instruction[NBITS_O-1:0];
      case (opcode)
        OPC_STO:  o_WrRam = 1'b1;
        OPC_LD:   begin o_WrAcc = 1'b1; o_RdRam = 1'b1; end
        OPC_LDI:  begin o_SelA = 2'b01; o_WrAcc = 1'b1; end
        OPC_ADD:  begin o_SelA = 2'b10; o_WrAcc = 1'b1; o_RdRam = 1'b1; end
        OPC_ADDI: begin o_SelA = 2'b10; o_SelB = 1'b1; o_WrAcc = 1'b1; end
        OPC_SUB:  begin o_SelA = 2'b10; o_Op = 1'b1; o_WrAcc = 1'b1; o_RdRam = 1'b1; end
        OPC_SUBI: begin o_SelA = 2'b10; o_SelB = 1'b1; o_Op = 1'b1; o_WrAcc = 1'b1; end
        default:  ;
      endcase
    end
  end

  assign o_PC       = pc_q;
  assign o_CycleCnt = cnt_q;
  assign o_Halt     = (state_q == HALT);

endmodule

// File: tb/tb_bip_control_unit.sv
// Testbench for bip_control_unit: program memory lives here, a behavioural
// model tracks mode/PC/count from the instruction semantics, and every
// negative clock edge compares the DUT outputs against it.
module tb_bip_control_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_Instruction;
  logic [10:0] o_PC;
  logic [1:0]  o_SelA;
  logic        o_SelB, o_WrAcc, o_Op, o_RdRam, o_WrRam, o_Halt;
  logic [10:0] o_Operand;
  logic [31:0] o_CycleCnt;

  logic [15:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  bip_control_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_Instruction(i_Instruction), .o_PC(o_PC), .o_SelA(o_SelA),
    .o_SelB(o_SelB), .o_WrAcc(o_WrAcc), .o_Op(o_Op), .o_Operand(o_Operand),
    .o_RdRam(o_RdRam), .o_WrRam(o_WrRam), .o_Halt(o_Halt),
    .o_CycleCnt(o_CycleCnt)
  );

  assign i_Instruction = mem[o_PC];

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Decode table, packed as {SelA[1:0], SelB, Op, WrAcc, RdRam, WrRam}.
  function automatic logic [6:0] row(input logic [4:0] op);
    case (op)
      5'd1:    return 7'b00_0_0_0_0_1;
      5'd2:    return 7'b00_0_0_1_1_0;
      5'd3:    return 7'b01_0_0_1_0_0;
      5'd4:    return 7'b10_0_0_1_1_0;
      5'd5:    return 7'b10_1_0_1_0_0;
      5'd6:    return 7'b10_0_1_1_1_0;
      5'd7:    return 7'b10_1_1_1_0_0;
      default: return 7'b0;
    endcase
  endfunction

  // Model: mode 0 idle, 1 running, 2 halted.
  int          m_mode = 0;
  logic [10:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  logic [4:0]  m_op;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_mode = 0; m_pc = '0; m_cnt = '0;
    end else if (m_mode == 1) begin
      m_op = mem[m_pc][15:11];
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_op == 5'd0) m_mode = 2;
      else m_pc = 11'((int'(m_pc) + 1) % 2048);
    end else if (i_start) begin
      m_mode = 1; m_pc = '0; m_cnt = '0;
    end
  end

  logic [15:0] c_ins;
  logic [6:0]  c_row;

  always @(negedge i_clk) begin
    c_ins = mem[m_pc];
    c_row = (m_mode == 1) ? row(c_ins[15:11]) : 7'b0;
    check("pc",      32'(o_PC),       32'(m_pc));
    check("sela",    32'(o_SelA),     32'(c_row[6:5]));
    check("selb",    32'(o_SelB),     32'(c_row[4]));
    check("op",      32'(o_Op),       32'(c_row[3]));
    check("wracc",   32'(o_WrAcc),    32'(c_row[2]));
    check("rdram",   32'(o_RdRam),    32'(c_row[1]));
    check("wrram",   32'(o_WrRam),    32'(c_row[0]));
    check("operand", 32'(o_Operand),  (m_mode == 1) ? 32'(c_ins[10:0]) : 32'd0);
    check("halt",    32'(o_Halt),     32'(m_mode == 2));
    check("cnt",     o_CycleCnt,      m_cnt);
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic load_sample();
    for (int a = 0; a < 2048; a++) mem[a] = 16'hF800;
    mem[0] = 16'h1805;  // LDI 5
    mem[1] = 16'h2803;  // ADDI 3
    mem[2] = 16'h0807;  // STO 7
    mem[3] = 16'h0000;  // HLT
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0] op;
    if ($urandom_range(0, 19) == 0) op = 5'd0;
    else if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(8, 31));
    else op = 5'($urandom_range(1, 7));
    return {op, 11'($urandom_range(0, 2047))};
  endfunction

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 16'hF800;

    // Reset held, then idle with no start.
    repeat (3) tick();
    check("rst_pc", 32'(o_PC), 32'd0);
    check("rst_wrram", 32'(o_WrRam), 32'd0);
    i_reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_pc", 32'(o_PC), 32'd0);
      check("idle_halt", 32'(o_Halt), 32'd0);
      check("idle_ctl", 32'({o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam}), 32'd0);
    end

    // Sample program LDI 5; ADDI 3; STO 7; HLT.
    load_sample();
    pulse_start();
    check("p_sela0", 32'(o_SelA), 32'd1);
    tick();
    check("p_sela1", 32'(o_SelA), 32'd2);
    check("p_selb1", 32'(o_SelB), 32'd1);
    tick();
    check("p_sela2", 32'(o_SelA), 32'd0);
    check("p_wrram2", 32'(o_WrRam), 32'd1);
    check("p_opnd2", 32'(o_Operand), 32'd7);
    tick();
    tick();
    check("p_halt", 32'(o_Halt), 32'd1);
    check("p_pc", 32'(o_PC), 32'd3);
    check("p_cnt", o_CycleCnt, 32'd4);

    // Every opcode row, then the 11111 NOP, then HLT.
    for (int k = 0; k < 7; k++) mem[k] = {5'(k + 1), 11'($urandom_range(0, 2047))};
    mem[7] = {5'b11111, 11'h2AA};
    mem[8] = 16'h0000;
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      if (k == 1) check("d_ld", 32'({o_WrAcc, o_RdRam, o_WrRam}), 32'b110);
      if (k == 6) check("d_subi", 32'({o_SelA, o_SelB, o_Op, o_WrAcc}), 32'b10111);
      if (k == 7) begin
        check("d_nop_ctl", 32'({o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam}), 32'd0);
        check("d_nop_pc", 32'(o_PC), 32'd7);
      end
      if (k == 8) check("d_nop_adv", 32'(o_PC), 32'd8);
      tick();
    end
    check("d_halt", 32'(o_Halt), 32'd1);
    check("d_cnt", o_CycleCnt, 32'd9);

    // Full-memory NOP run with PC wrap; HLT planted at 0 once it has been passed.
    for (int a = 0; a < 2048; a++) mem[a] = {5'b11111, 11'(a)};
    pulse_start();
    tick();
    mem[0] = 16'h0000;
    begin
      int n;
      n = 0;
      while (!o_Halt && n < 2200) begin
        tick();
        n++;
      end
      check("w_timeout", 32'(o_Halt), 32'd1);
    end
    check("w_pc", 32'(o_PC), 32'd0);
    check("w_cnt", o_CycleCnt, 32'd2049);

    // Restart from HALT; start while running is ignored.
    load_sample();
    pulse_start();
    check("r_pc", 32'(o_PC), 32'd0);
    check("r_cnt", o_CycleCnt, 32'd0);
    check("r_sela", 32'(o_SelA), 32'd1);
    tick();
    pulse_start();
    check("r_ign_pc", 32'(o_PC), 32'd2);
    check("r_ign_cnt", o_CycleCnt, 32'd2);
    tick();
    tick();
    check("r_halt", 32'(o_Halt), 32'd1);

    // Asynchronous reset during STO.
    mem[0] = 16'h0807;
    mem[1] = 16'hF800;
    pulse_start();
    check("a_wrram_on", 32'(o_WrRam), 32'd1);
    #1 i_reset = 1'b0;
    #1;
    check("a_wrram_off", 32'(o_WrRam), 32'd0);
    check("a_pc", 32'(o_PC), 32'd0);
    check("a_cnt", o_CycleCnt, 32'd0);
    tick();
    i_reset = 1'b1;
    tick();
    check("a_idle_pc", 32'(o_PC), 32'd0);
    check("a_idle_ctl", 32'(o_WrRam), 32'd0);

    // Randomized programs, start pulses and occasional resets.
    for (int blk = 0; blk < 6; blk++) begin
      for (int a = 0; a < 2048; a++) mem[a] = rand_instr();
      for (int k = 0; k < 500; k++) begin
        i_start = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 199) == 0) begin
          i_reset = 1'b0;
          #1;
          check("rnd_rst_wr", 32'(o_WrRam), 32'd0);
          tick();
          i_reset = 1'b1;
        end
        tick();
      end
      i_start = 1'b0;
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
